// File: rtl/rcpu_uart_io.sv
// Memory-mapped 8N1 UART for the RCPU I/O bus: TX FIFO, single-byte RX holding register, sticky flags.
// Optional CTRL loopback bit is built only when UART_IO_LOOPBACK_EN is defined.
module rcpu_uart_io #(
   parameter int unsigned CLKS_PER_BIT = 104,
   parameter int unsigned TX_DEPTH     = 4,
   parameter logic [0:15] BASE         = 16'hFF00
) (
   input  logic        clk,
   input  logic        resetq,
   input  logic        io_read_enable,
   input  logic        io_write_enable,
   input  logic [0:15] io_address,
   input  logic [15:0] io_write_data,
   output logic [15:0] io_read_data,
   output logic        uart_tx,
   input  logic        uart_rx
);
   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam int unsigned PW = $clog2(TX_DEPTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [1:0] StIdle = 2'd0, StStart = 2'd1, StData = 2'd2, StStop = 2'd3;

   logic sel, sel_data, sel_stat, sel_ctrl, data_wr, data_rd, stat_wr;
   assign sel      = io_address[0:7] == BASE[0:7];
   assign sel_data = sel && io_address[8:15] == 8'h00;
   assign sel_stat = sel && io_address[8:15] == 8'h04;
   assign sel_ctrl = sel && io_address[8:15] == 8'h08;
   assign data_wr  = io_write_enable && sel_data;
   assign data_rd  = io_read_enable && sel_data;
   assign stat_wr  = io_write_enable && sel_stat;

   logic [7:0]    fifo_q [TX_DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PW:0]   count_q, count_d;
   logic          tx_full, tx_empty, push, pop, tx_idle, tx_end;
   logic [1:0]    tx_state_q, tx_state_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]    tx_bit_q, tx_bit_d;
   logic [7:0]    tx_shift_q, tx_shift_d;
   logic          tx_line_q, tx_line_d;

   assign tx_full  = count_q == (PW + 1)'(TX_DEPTH);
   assign tx_empty = count_q == '0;
   assign tx_idle  = tx_empty && tx_state_q == StIdle;
   assign tx_end   = tx_cnt_q == CNT_LAST;
   assign push     = data_wr && !tx_full;
   // Back-to-back frames: the next byte is taken at the last STOP cycle
   assign pop      = !tx_empty && (tx_state_q == StIdle || (tx_state_q == StStop && tx_end));

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_line_d  = tx_line_q;
      count_d    = count_q;
      if (push && !pop) count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
      if (tx_state_q != StIdle && !tx_end) tx_cnt_d = tx_cnt_q + 1'b1;
      if (pop) begin
         tx_state_d = StStart;
         tx_cnt_d   = '0;
         tx_shift_d = fifo_q[rd_ptr_q];
         tx_line_d  = 1'b0;
      end else if (tx_end) begin
         unique case (tx_state_q)
            StStart: begin
               tx_state_d = StData;
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_line_d  = tx_shift_q[0];
            end
            StData: begin
               tx_cnt_d = '0;
               if (tx_bit_q == 3'd7) begin
                  tx_state_d = StStop;
                  tx_line_d  = 1'b1;
               end else begin
                  tx_bit_d   = tx_bit_q + 1'b1;
                  tx_shift_d = tx_shift_q >> 1;
                  tx_line_d  = tx_shift_q[1];
               end
            end
            StStop:  tx_state_d = StIdle;
            default: ;
         endcase
      end
   end

   logic rx_in, rx_meta_q, rx_sync_q, rx_prev_q;
   logic lb_q, lb_d;
`ifdef UART_IO_LOOPBACK_EN
   assign rx_in   = lb_q ? tx_line_q : uart_rx;
   assign uart_tx = lb_q | tx_line_q;
   assign lb_d    = (io_write_enable && sel_ctrl) ? io_write_data[0] : lb_q;
`else
   assign rx_in   = uart_rx;
   assign uart_tx = tx_line_q;
   assign lb_d    = 1'b0;
`endif

   logic [1:0]    rx_state_q, rx_state_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_shift_q, rx_shift_d, rx_byte_q, rx_byte_d;
   logic          rx_valid_q, rx_valid_d, overrun_q, overrun_d;
   logic          overflow_q, overflow_d, framing_q, framing_d, rx_end;
   logic [15:0]   rd_d;

   assign rx_end = rx_cnt_q == ((rx_state_q == StStart) ? CNT_HALF : CNT_LAST);

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_byte_d  = rx_byte_q;
      rx_valid_d = rx_valid_q && !data_rd;
      overrun_d  = overrun_q && !(stat_wr && io_write_data[3]);
      overflow_d = (overflow_q && !(stat_wr && io_write_data[4])) || (data_wr && tx_full);
      framing_d  = framing_q && !(stat_wr && io_write_data[5]);
      if (rx_state_q != StIdle && !rx_end) rx_cnt_d = rx_cnt_q + 1'b1;
      unique case (rx_state_q)
         StIdle: begin
            if (rx_prev_q && !rx_sync_q) begin
               rx_state_d = StStart;
               rx_cnt_d   = '0;
            end
         end
         StStart: begin
            if (rx_end) begin
               rx_state_d = rx_sync_q ? StIdle : StData;
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
            end
         end
         StData: begin
            if (rx_end) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
               rx_bit_d   = rx_bit_q + 1'b1;
               if (rx_bit_q == 3'd7) rx_state_d = StStop;
            end
         end
         default: begin
            if (rx_end) begin
               rx_state_d = StIdle;
               // A same-cycle DATA read frees the holding register for the new byte
               if (!rx_sync_q) framing_d = 1'b1;
               else if (rx_valid_q && !data_rd) overrun_d = 1'b1;
               else begin
                  rx_byte_d  = rx_shift_q;
                  rx_valid_d = 1'b1;
               end
            end
         end
      endcase
      rd_d = '0;
      if (sel_data && rx_valid_q) rd_d = {8'h01, rx_byte_q};
      else if (sel_stat) rd_d = {10'b0, framing_q, overflow_q, overrun_q, tx_idle, tx_full, rx_valid_q};
      else if (sel_ctrl) rd_d = {15'b0, lb_q};
   end

   logic unused_wdata;
   assign unused_wdata = ^{io_write_data[15:8], io_write_data[2:0]};

   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= io_write_data[7:0];
   end

   always_ff @(posedge clk) begin
      if (!resetq) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         tx_state_q   <= StIdle;
         tx_cnt_q     <= '0;
         tx_bit_q     <= '0;
         tx_shift_q   <= '0;
         tx_line_q    <= 1'b1;
         rx_meta_q    <= 1'b1;
         rx_sync_q    <= 1'b1;
         rx_prev_q    <= 1'b1;
         rx_state_q   <= StIdle;
         rx_cnt_q     <= '0;
         rx_bit_q     <= '0;
         rx_shift_q   <= '0;
         rx_byte_q    <= '0;
         rx_valid_q   <= 1'b0;
         overrun_q    <= 1'b0;
         overflow_q   <= 1'b0;
         framing_q    <= 1'b0;
         lb_q         <= 1'b0;
         io_read_data <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_q + PW'(push);
         rd_ptr_q   <= rd_ptr_q + PW'(pop);
         count_q    <= count_d;
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_line_q  <= tx_line_d;
         rx_meta_q  <= rx_in;
         rx_sync_q  <= rx_meta_q;
         rx_prev_q  <= rx_sync_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_byte_q  <= rx_byte_d;
         rx_valid_q <= rx_valid_d;
         overrun_q  <= overrun_d;
         overflow_q <= overflow_d;
         framing_q  <= framing_d;
         lb_q       <= lb_d;
         if (io_read_enable) io_read_data <= rd_d;
      end
   end

endmodule

// File: tb/tb_rcpu_uart_io.sv
// Bench for rcpu_uart_io: frame-level reference model checked every cycle, plus literal spot checks.
// Exercises the CTRL loopback path when UART_IO_LOOPBACK_EN is defined.
module tb_rcpu_uart_io;
   localparam int C = 8;
   localparam int D = 4;
`ifdef UART_IO_LOOPBACK_EN
   localparam bit LB = 1'b1;
`else
   localparam bit LB = 1'b0;
`endif

   logic        clk = 1'b0, resetq = 1'b0, rd_en = 1'b0, wr_en = 1'b0, uart_rx = 1'b1;
   logic [15:0] addr = '0, wdata = '0;
   logic [15:0] rdata;
   logic        uart_tx;

   always #5 clk = ~clk;

   rcpu_uart_io #(.CLKS_PER_BIT(C), .TX_DEPTH(D), .BASE(16'hFF00)) dut (
      .clk             (clk),
      .resetq          (resetq),
      .io_read_enable  (rd_en),
      .io_write_enable (wr_en),
      .io_address      (addr),
      .io_write_data   (wdata),
      .io_read_data    (rdata),
      .uart_tx         (uart_tx),
      .uart_rx         (uart_rx)
   );

   // Reference model: a byte queue and a frame timer; line value derived from the frame position.
   logic [7:0]  m_q[$];
   logic        m_busy = 1'b0, m_rxv = 1'b0, m_ovr = 1'b0, m_ovf = 1'b0, m_fe = 1'b0, m_ctrl = 1'b0;
   int          m_t = 0;
   logic [7:0]  m_byte = '0, m_rxb = '0;
   logic [15:0] m_rd = '0;
   logic        m_tx = 1'b1;
   int          rx_req_n = 0, rx_seen_n = 0;
   logic [7:0]  rx_req_b = '0;
   logic        rx_req_ok = 1'b1;
   int          n_cmp = 0, n_err = 0;
   logic        chk_on = 1'b0;

   function automatic logic frame_bit(input logic [7:0] b, input int t);
      int k = t / C;
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      return 1'b1;
   endfunction

   always @(posedge clk) begin
      int pre;
      logic sel, push_ok;
      logic [7:0] off;
      logic [15:0] rd;
      if (!resetq) begin
         m_q.delete();
         m_busy = 0; m_t = 0; m_rxv = 0; m_ovr = 0; m_ovf = 0; m_fe = 0; m_ctrl = 0; m_rd = '0;
         rx_seen_n = rx_req_n;
      end else begin
         sel = addr[15:8] == 8'hFF;
         off = addr[7:0];
         pre = m_q.size();
         if (rd_en) begin
            rd = '0;
            if (sel && off == 8'h00 && m_rxv) rd = 16'h0100 + 16'(m_rxb);
            else if (sel && off == 8'h04)
               rd = (m_rxv ? 16'h1 : 16'h0) + (pre == D ? 16'h2 : 16'h0)
                  + ((pre == 0 && !m_busy) ? 16'h4 : 16'h0) + (m_ovr ? 16'h8 : 16'h0)
                  + (m_ovf ? 16'h10 : 16'h0) + (m_fe ? 16'h20 : 16'h0);
            else if (sel && off == 8'h08) rd = m_ctrl ? 16'h1 : 16'h0;
            m_rd = rd;
            if (sel && off == 8'h00) m_rxv = 0;
         end
         if (wr_en && sel && off == 8'h04) begin
            if (wdata[3]) m_ovr = 0;
            if (wdata[4]) m_ovf = 0;
            if (wdata[5]) m_fe = 0;
         end
         if (wr_en && sel && off == 8'h08) m_ctrl = LB && wdata[0];
         push_ok = pre < D;
         if (m_busy) begin
            if (m_t == 10 * C - 1) m_busy = 0;
            else m_t++;
         end
         if (!m_busy && pre > 0) begin
            m_byte = m_q.pop_front();
            m_busy = 1;
            m_t = 0;
         end
         if (wr_en && sel && off == 8'h00) begin
            if (push_ok) m_q.push_back(wdata[7:0]);
            else m_ovf = 1;
         end
         if (rx_req_n != rx_seen_n) begin
            rx_seen_n++;
            if (!rx_req_ok) m_fe = 1;
            else if (m_rxv) m_ovr = 1;
            else begin
               m_rxv = 1;
               m_rxb = rx_req_b;
            end
         end
      end
      m_tx = (m_ctrl || !m_busy) ? 1'b1 : frame_bit(m_byte, m_t);
   end

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
      end
   endtask

   task automatic op(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
      rd_en = r; wr_en = w; addr = a; wdata = d;
      @(posedge clk); #1;
      rd_en = 0; wr_en = 0;
   endtask

   task automatic rd_chk(input logic [15:0] a, input logic [15:0] exp, input string name);
      op(1'b1, 1'b0, a, 16'h0);
      @(negedge clk);
      check(name, rdata, exp);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         uart_rx = f[i];
         idle(C);
      end
      uart_rx = 1'b1;
      idle(4);
      rx_req_b = b; rx_req_ok = stop; rx_req_n++;
      idle(4);
   endtask

   initial begin
      logic [9:0] exp_bits;
      fork
         forever begin
            @(negedge clk);
            if (chk_on) begin
               check("model_uart_tx", {15'b0, uart_tx}, {15'b0, m_tx});
               check("model_read_data", rdata, m_rd);
            end
         end
      join_none

      idle(3);
      resetq = 1'b1;
      chk_on = 1'b1;
      check("reset_uart_tx", {15'b0, uart_tx}, 16'h0001);
      check("reset_read_data", rdata, 16'h0000);
      rd_chk(16'hFF04, 16'h0004, "status_after_reset");

      // Single frame 0xA5: sample the middle of every bit
      exp_bits = {1'b1, 8'hA5, 1'b0};
      op(1'b0, 1'b1, 16'hFF00, 16'h00A5);
      for (int k = 0; k < 10; k++) begin
         idle(k == 0 ? 1 + C / 2 : C);
         check("tx_a5_bit", {15'b0, uart_tx}, {15'b0, exp_bits[k]});
      end
      idle(8);
      rd_chk(16'hFF04, 16'h0004, "status_after_frame");

      // Overflow: one byte in the shifter, four queued, one dropped
      op(1'b0, 1'b1, 16'hFF00, 16'h00A1);
      idle(2);
      for (int i = 0; i < 5; i++) op(1'b0, 1'b1, 16'hFF00, 16'h00A2 + 16'(i));
      rd_chk(16'hFF04, 16'h0012, "status_full_overflow");
      op(1'b0, 1'b1, 16'hFF04, 16'h0010);
      rd_chk(16'hFF04, 16'h0002, "status_overflow_cleared");
      idle(5 * 10 * C);
      rd_chk(16'hFF04, 16'h0004, "status_after_burst");

      // RX single byte
      send_rx(8'h3C, 1'b1);
      rd_chk(16'hFF04, 16'h0005, "status_rx_valid");
      rd_chk(16'hFF00, 16'h013C, "rx_data_3c");
      rd_chk(16'hFF04, 16'h0004, "status_rx_popped");
      rd_chk(16'hFF00, 16'h0000, "rx_data_empty");

      // Overrun, then framing error
      send_rx(8'h11, 1'b1);
      send_rx(8'h22, 1'b1);
      rd_chk(16'hFF04, 16'h000D, "status_overrun");
      send_rx(8'h33, 1'b0);
      rd_chk(16'hFF04, 16'h002D, "status_framing");
      rd_chk(16'hFF00, 16'h0111, "rx_first_byte_kept");
      op(1'b0, 1'b1, 16'hFF04, 16'h0038);
      rd_chk(16'hFF04, 16'h0004, "status_w1c_all");

      // Decode: foreign base, unmapped offset, CTRL reset value
      op(1'b0, 1'b1, 16'hFE00, 16'h0055);
      idle(3);
      check("foreign_write_no_tx", {15'b0, uart_tx}, 16'h0001);
      rd_chk(16'hFE04, 16'h0000, "foreign_read");
      rd_chk(16'hFF0C, 16'h0000, "unmapped_read");
      rd_chk(16'hFF08, 16'h0000, "ctrl_reset");

      // Same-cycle DATA read and DATA write
      send_rx(8'h5A, 1'b1);
      op(1'b1, 1'b1, 16'hFF00, 16'h0077);
      @(negedge clk);
      check("rdwr_same_cycle", rdata, 16'h015A);
      @(posedge clk); #1;
      rd_chk(16'hFF04, 16'h0000, "status_tx_busy");
      idle(10 * C + 4);

`ifdef UART_IO_LOOPBACK_EN
      op(1'b0, 1'b1, 16'hFF08, 16'h0001);
      rd_chk(16'hFF08, 16'h0001, "ctrl_set");
      op(1'b0, 1'b1, 16'hFF00, 16'h0042);
      idle(10 * C + 10);
      check("loopback_tx_high", {15'b0, uart_tx}, 16'h0001);
      rx_req_b = 8'h42; rx_req_ok = 1'b1; rx_req_n++;
      idle(2);
      rd_chk(16'hFF00, 16'h0142, "loopback_data");
      op(1'b0, 1'b1, 16'hFF08, 16'h0000);
`endif

      // Reset mid-frame with flags set
      send_rx(8'h77, 1'b1);
      send_rx(8'h78, 1'b1);
      rd_chk(16'hFF04, 16'h000D, "status_before_reset");
      op(1'b0, 1'b1, 16'hFF00, 16'h0099);
      idle(30);
`ifdef UART_IO_LOOPBACK_EN
      op(1'b0, 1'b1, 16'hFF08, 16'h0001);
`endif
      resetq = 1'b0;
      idle(1);
      check("midframe_reset_tx", {15'b0, uart_tx}, 16'h0001);
      check("midframe_reset_rdata", rdata, 16'h0000);
      resetq = 1'b1;
      rd_chk(16'hFF04, 16'h0004, "status_after_midreset");
      rd_chk(16'hFF08, 16'h0000, "ctrl_after_midreset");
      idle(10 * C);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
